// File: rtl/cache_pkg.sv
// Shared definitions for set_assoc_cache: FSM state codes, derived widths and
// the bit layout of one cache line, packed as {valid, dirty, mru, tag, data}.
package cache_pkg;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOOKUP  = 3'd1;
    localparam logic [2:0] WB      = 3'd2;
    localparam logic [2:0] RF_REQ  = 3'd3;
    localparam logic [2:0] RF_WAIT = 3'd4;
    localparam logic [2:0] RESP    = 3'd5;

    localparam int unsigned LINE_DATA_OFF = 0;

    function automatic int unsigned calc_tag_w(int unsigned addr_w, int unsigned set_bits);
        return addr_w - set_bits;
    endfunction

    function automatic int unsigned calc_sets(int unsigned set_bits);
        return 1 << set_bits;
    endfunction

    function automatic int unsigned line_tag_off(int unsigned data_w);
        return data_w;
    endfunction

    function automatic int unsigned line_mru_off(int unsigned data_w, int unsigned tag_w);
        return data_w + tag_w;
    endfunction

    function automatic int unsigned line_dirty_off(int unsigned data_w, int unsigned tag_w);
        return data_w + tag_w + 1;
    endfunction

    function automatic int unsigned line_valid_off(int unsigned data_w, int unsigned tag_w);
        return data_w + tag_w + 2;
    endfunction

    function automatic int unsigned line_width(int unsigned data_w, int unsigned tag_w);
        return data_w + tag_w + 3;
    endfunction

endpackage

// File: rtl/mru_policy.sv
// MRU-bit pseudo-LRU: picks a victim way and computes the set's MRU bits
// after an access to i_acc_way.
module mru_policy #(
    parameter int unsigned WAYS = 4
) (
    input  logic [WAYS-1:0]         i_valid,
    input  logic [WAYS-1:0]         i_mru,
    input  logic [$clog2(WAYS)-1:0] i_acc_way,
    output logic [$clog2(WAYS)-1:0] o_victim,
    output logic [WAYS-1:0]         o_mru_next
);
    localparam int unsigned WAY_W = $clog2(WAYS);

    logic            w_found;
    logic [WAYS-1:0] w_acc_bit;
    logic [WAYS-1:0] w_set_bits;

    always_comb begin
        o_victim = '0;
        w_found  = 1'b0;
        // Invalid ways take priority over any MRU-based choice.
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (!w_found && !i_valid[i]) begin
                o_victim = WAY_W'(i);
                w_found  = 1'b1;
            end
        end
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (!w_found && !i_mru[i]) begin
                o_victim = WAY_W'(i);
                w_found  = 1'b1;
            end
        end
        w_acc_bit  = WAYS'(1) << i_acc_way;
        w_set_bits = i_mru | w_acc_bit;
        o_mru_next = (&w_set_bits) ? w_acc_bit : w_set_bits;
    end

endmodule

// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back cache with MRU-bit replacement, refilling
// from and writing dirty victims back to a valid/ready memory port.
module set_assoc_cache
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned SET_BITS = 2,
    parameter int unsigned WAYS     = 4,
    parameter int unsigned DATA_W   = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] address,
    input  logic              wren,
    input  logic [DATA_W-1:0] write,
    output logic              resp_valid,
    output logic [DATA_W-1:0] outWord,
    output logic              hit,
    output logic              writeBack,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int unsigned TAG_W   = calc_tag_w(ADDR_W, SET_BITS);
    localparam int unsigned SETS    = calc_sets(SET_BITS);
    localparam int unsigned WAY_W   = $clog2(WAYS);
    localparam int unsigned O_DATA  = LINE_DATA_OFF;
    localparam int unsigned O_TAG   = line_tag_off(DATA_W);
    localparam int unsigned O_MRU   = line_mru_off(DATA_W, TAG_W);
    localparam int unsigned O_DIRTY = line_dirty_off(DATA_W, TAG_W);
    localparam int unsigned O_VALID = line_valid_off(DATA_W, TAG_W);
    localparam int unsigned LINE_W  = line_width(DATA_W, TAG_W);

    logic [LINE_W-1:0] r_lines [SETS][WAYS];
    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wren;
    logic [DATA_W-1:0] r_wdata;
    logic [WAY_W-1:0]  r_way;
    logic              r_evict;
    logic              r_hit;
    logic              r_wb;
    logic [DATA_W-1:0] r_out;

    logic [SET_BITS-1:0] w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [WAYS-1:0]     w_valid, w_mru, w_match, w_mru_next;
    logic [WAY_W-1:0]    w_hit_way, w_victim, w_acc_way;
    logic                w_vic_dirty;
    logic [DATA_W-1:0]   w_hit_data;
    logic [LINE_W-1:0]   w_set_next [WAYS];

    assign w_idx = r_addr[SET_BITS-1:0];
    assign w_tag = r_addr[ADDR_W-1:SET_BITS];

    always_comb begin
        w_valid   = '0;
        w_mru     = '0;
        w_match   = '0;
        w_hit_way = '0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            w_valid[i] = r_lines[w_idx][i][O_VALID];
            w_mru[i]   = r_lines[w_idx][i][O_MRU];
            w_match[i] = w_valid[i] && (r_lines[w_idx][i][O_TAG +: TAG_W] == w_tag);
            if (w_match[i]) w_hit_way = WAY_W'(i);
        end
    end

    assign w_acc_way   = (r_state == LOOKUP) ? w_hit_way : r_way;
    assign w_hit_data  = r_lines[w_idx][w_hit_way][O_DATA +: DATA_W];
    assign w_vic_dirty = r_lines[w_idx][w_victim][O_VALID] & r_lines[w_idx][w_victim][O_DIRTY];

    mru_policy #(.WAYS(WAYS)) u_mru (
        .i_valid   (w_valid),
        .i_mru     (w_mru),
        .i_acc_way (w_acc_way),
        .o_victim  (w_victim),
        .o_mru_next(w_mru_next)
    );

    // Next contents of the addressed set: hit update in LOOKUP, refill install otherwise.
    always_comb begin
        w_set_next = r_lines[w_idx];
        for (int unsigned i = 0; i < WAYS; i++) begin
            w_set_next[i][O_MRU] = w_mru_next[i];
        end
        if (r_state == LOOKUP) begin
            if (r_wren) begin
                w_set_next[w_acc_way][O_DATA +: DATA_W] = r_wdata;
                w_set_next[w_acc_way][O_DIRTY]          = 1'b1;
            end
        end else begin
            w_set_next[w_acc_way][O_VALID]          = 1'b1;
            w_set_next[w_acc_way][O_DIRTY]          = r_wren;
            w_set_next[w_acc_way][O_TAG +: TAG_W]   = w_tag;
            w_set_next[w_acc_way][O_DATA +: DATA_W] = r_wren ? r_wdata : mem_rdata;
        end
    end

    assign req_ready     = (r_state == IDLE);
    assign resp_valid    = (r_state == RESP);
    assign mem_req_valid = (r_state == WB) || (r_state == RF_REQ);
    assign mem_we        = (r_state == WB);
    assign mem_addr      = (r_state == WB)     ? {r_lines[w_idx][r_way][O_TAG +: TAG_W], w_idx} :
                           (r_state == RF_REQ) ? r_addr : '0;
    assign mem_wdata     = (r_state == WB) ? r_lines[w_idx][r_way][O_DATA +: DATA_W] : '0;
    assign outWord       = r_out;
    assign hit           = r_hit;
    assign writeBack     = r_wb;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_wren  <= 1'b0;
            r_wdata <= '0;
            r_way   <= '0;
            r_evict <= 1'b0;
            r_hit   <= 1'b0;
            r_wb    <= 1'b0;
            r_out   <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    r_lines[s][w] <= '0;
                end
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_addr  <= address;
                        r_wren  <= wren;
                        r_wdata <= write;
                        r_state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (|w_match) begin
                        r_lines[w_idx] <= w_set_next;
                        r_hit          <= 1'b1;
                        r_wb           <= 1'b0;
                        r_out          <= r_wren ? r_wdata : w_hit_data;
                        r_state        <= RESP;
                    end else begin
                        r_way   <= w_victim;
                        r_evict <= w_vic_dirty;
                        r_state <= w_vic_dirty ? WB : RF_REQ;
                    end
                end
                WB: begin
                    if (mem_req_ready) r_state <= RF_REQ;
                end
                RF_REQ: begin
                    if (mem_req_ready) r_state <= RF_WAIT;
                end
                RF_WAIT: begin
                    if (mem_rvalid) begin
                        r_lines[w_idx] <= w_set_next;
                        r_hit          <= 1'b0;
                        r_wb           <= r_evict;
                        r_out          <= r_wren ? r_wdata : mem_rdata;
                        r_state        <= RESP;
                    end
                end
                RESP: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
